// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the dinosaur game run-state controller.
// Optional build macro: GAME_SEQ_HISCORE_EN (enables the best-score register).
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  localparam int          SCORE_DIGITS = 4;
  localparam logic [15:0] BCD_MAX      = 16'h9999;
  localparam int          SPEED_W      = 4;

  // True when BCD value a is strictly greater than b, deciding on the most
  // significant differing digit.
  function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
    logic done;
    logic gt;
    done = 1'b0;
    gt   = 1'b0;
    for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
      if (!done && (a[i*4 +: 4] != b[i*4 +: 4])) begin
        gt   = (a[i*4 +: 4] > b[i*4 +: 4]);
        done = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Button/VGA inputs and game-state outputs shared between the sequencer and
// the Jump, Ground, Cactus and Frame blocks.
interface game_sequencer_if;
  import game_pkg::*;

  logic               start;
  logic               vs;
  logic               px_dinosaur;
  logic               px_cactus;
  logic               game_status;
  logic               game_over;
  logic [SPEED_W-1:0] speed;
  logic [15:0]        score;
  logic [15:0]        hiscore;

  // Stimulus side (buttons, VGA timing, pixel detectors)
  modport master (
    output start, vs, px_dinosaur, px_cactus,
    input  game_status, game_over, speed, score, hiscore
  );

  // Sequencer side
  modport slave (
    input  start, vs, px_dinosaur, px_cactus,
    output game_status, game_over, speed, score, hiscore
  );
endinterface

// File: rtl/game_sequencer_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear; holds at 9999 and flags it.
module bcd_counter4
  import game_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] value_o,
  output logic        sat_o
);

  logic [15:0] val_q, val_d;
  logic        carry;

  assign sat_o   = (val_q == BCD_MAX);
  assign value_o = val_q;

  // Ripple a +1 through the digits; increments at 9999 are dropped.
  always_comb begin
    val_d = val_q;
    carry = 1'b0;
    if (clr_i) begin
      val_d = '0;
    end else if (inc_i && !sat_o) begin
      carry = 1'b1;
      for (int i = 0; i < SCORE_DIGITS; i++) begin
        if (carry) begin
          if (val_q[i*4 +: 4] == 4'd9) begin
            val_d[i*4 +: 4] = 4'd0;
          end else begin
            val_d[i*4 +: 4] = val_q[i*4 +: 4] + 4'd1;
            carry           = 1'b0;
          end
        end
      end
    end
  end

  // Count register
  always_ff @(posedge CLK) begin
    if (RESET) val_q <= '0;
    else       val_q <= val_d;
  end

endmodule

// File: rtl/game_sequencer.sv
// Run-state controller: arm on START, launch on vsync fall, stop on pixel
// collision, BCD scoring and speed scheduling.
// Optional build macro: GAME_SEQ_HISCORE_EN keeps the best score across runs;
// without it hiscore reads 0x0000.
module game_sequencer
  import game_pkg::*;
#(
  parameter int FRAMES_PER_POINT = 6,
  parameter int POINTS_PER_LEVEL = 100,
  parameter int SPEED_MIN        = 1,
  parameter int SPEED_MAX        = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  game_sequencer_if.slave   bus
);

  localparam logic [5:0]         FRM_LAST = 6'(FRAMES_PER_POINT - 1);
  localparam logic [9:0]         LVL_LAST = 10'(POINTS_PER_LEVEL - 1);
  localparam logic [SPEED_W-1:0] SPD_MIN  = SPEED_W'(SPEED_MIN);
  localparam logic [SPEED_W-1:0] SPD_MAX  = SPEED_W'(SPEED_MAX);

  game_state_t        state_q, state_d;
  logic               vs_q, start_q;
  logic [5:0]         frm_q, frm_d;
  logic [9:0]         lvl_q, lvl_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               status_o, over_o;

  logic        frame_tick, start_edge, hit;
  logic        launch, run_tick, pt_inc, lvl_adv, sat;
  logic [15:0] score;

  assign frame_tick = vs_q & ~bus.vs;
  assign start_edge = bus.start & ~start_q;
  assign hit        = bus.px_dinosaur & bus.px_cactus;

  // Edge detectors idle high so a held button or low vsync at reset is no edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vs_q    <= 1'b1;
      start_q <= 1'b1;
    end else begin
      vs_q    <= bus.vs;
      start_q <= bus.start;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a start edge while armed or running is ignored
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_edge) state_d = ARMED;
      ARMED:   if (frame_tick) state_d = RUNNING;
      RUNNING: if (hit)        state_d = OVER;
      OVER:    if (start_edge) state_d = ARMED;
      default:                 state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded straight from the state register
  always_comb begin
    status_o = (state_q == RUNNING);
    over_o   = (state_q == OVER);
  end

  // Collision beats a coincident frame tick, so the final score is frozen
  assign launch   = (state_q == ARMED) && frame_tick;
  assign run_tick = (state_q == RUNNING) && frame_tick && !hit;
  assign pt_inc   = run_tick && (frm_q == FRM_LAST);
  assign lvl_adv  = pt_inc && !sat;

  // Frame, level and speed next-state
  always_comb begin
    frm_d   = frm_q;
    lvl_d   = lvl_q;
    speed_d = speed_q;
    if (launch) begin
      frm_d   = '0;
      lvl_d   = '0;
      speed_d = SPD_MIN;
    end else begin
      if (run_tick) frm_d = (frm_q == FRM_LAST) ? 6'd0 : frm_q + 6'd1;
      if (lvl_adv) begin
        if (lvl_q == LVL_LAST) begin
          lvl_d = '0;
          if (speed_q < SPD_MAX) speed_d = speed_q + 1'b1;
        end else begin
          lvl_d = lvl_q + 10'd1;
        end
      end
    end
  end

  // Frame, level and speed registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      frm_q   <= '0;
      lvl_q   <= '0;
      speed_q <= SPD_MIN;
    end else begin
      frm_q   <= frm_d;
      lvl_q   <= lvl_d;
      speed_q <= speed_d;
    end
  end

  bcd_counter4 u_score (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr_i   (launch),
    .inc_i   (pt_inc),
    .value_o (score),
    .sat_o   (sat)
  );

`ifdef GAME_SEQ_HISCORE_EN
  logic [15:0] hiscore_q;

  // Capture the final score as it enters OVER, if it beats the best so far
  always_ff @(posedge CLK) begin
    if (RESET)                                              hiscore_q <= '0;
    else if ((state_q == RUNNING) && hit && bcd_gt(score, hiscore_q)) hiscore_q <= score;
  end

  assign bus.hiscore = hiscore_q;
`else
  assign bus.hiscore = 16'h0000;
`endif

  assign bus.game_status = status_o;
  assign bus.game_over   = over_o;
  assign bus.speed       = speed_q;
  assign bus.score       = score;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Central run-state controller for the dinosaur game. It replaces ad hoc start/stop glue with one FSM that does four things: arms on the START button, launches only in vertical blanking, stops on dinosaur/cactus pixel overlap, and schedules scroll speed from a BCD score counter. It sits between the button/VGA signals and the Jump, Ground, Cactus and Frame modules, and drives their shared `game_status` and `speed` inputs.

## Interface
Parameters:
- `FRAMES_PER_POINT`, default 6 – frame ticks per score increment, range 1..63.
- `POINTS_PER_LEVEL`, default 100 – score points per speed step, range 1..1023.
- `SPEED_MIN`, default 1 – speed at run start.
- `SPEED_MAX`, default 8 – speed ceiling, must be ≤ 15.

Ports:
- `CLK` – input, 1 – system clock.
- `RESET` – input, 1 – synchronous, active-high; clock `CLK`.
- `start` – input, 1 – START button, active-high level, already synchronised.
- `vs` – input, 1 – VGA vsync, active-low.
- `px_dinosaur` – input, 1 – dinosaur pixel hit at the current scan position.
- `px_cactus` – input, 1 – cactus pixel hit at the current scan position.
- `game_status` – output, 1 – 1 while running.
- `game_over` – output, 1 – 1 in state OVER.
- `speed` – output, 4 – scroll speed for Ground and Cactus.
- `score` – output, 16 – 4-digit BCD; bits [15:12] are thousands.
- `hiscore` – output, 16 – 4-digit BCD best score.

## Operation
- **Frame tick.** `vs_q` is `vs` registered. `frame_tick = vs_q & ~vs` (falling edge), one cycle wide.
- **Start edge.** `start_edge = start & ~start_q`. Holding the button down produces one edge only.
- **Collision.** `hit = px_dinosaur & px_cactus`, evaluated every cycle.
- **FSM states:**
  - IDLE: reset state.
  - ARMED: start accepted; waiting for blanking.
  - RUNNING
  - OVER
- **FSM transitions:**
  - IDLE → ARMED on `start_edge`.
  - OVER → ARMED on `start_edge`.
  - ARMED → RUNNING on `frame_tick`.
    - On this transition: score cleared to 0, `speed` set to `SPEED_MIN`, frame and level counters cleared.
  - RUNNING → OVER on `hit`.
  - `start_edge` in ARMED or RUNNING is ignored.
- **Outputs by state:**
  - `game_status` = 1 only in RUNNING.
  - `game_over` = 1 only in OVER.
  - In ARMED, `score` still shows the previous run until launch.
- **Scoring (RUNNING only):**
  - 6-bit frame counter advances on each `frame_tick`.
  - When it reaches `FRAMES_PER_POINT-1`, it wraps to 0 and the score increments by 1 BCD.
  - Each digit wraps 9→0 with carry.
  - At 9999 the score saturates; no wrap to 0000.
- **Speed scheduling:**
  - A 10-bit level counter counts score increments.
  - When it reaches `POINTS_PER_LEVEL-1`, it wraps to 0 and `speed` increments, saturating at `SPEED_MAX`.
  - Increments suppressed by score saturation do not advance the level counter.
- **Simultaneous events:**
  - `hit` and `frame_tick` in the same cycle while RUNNING → `hit` wins: enter OVER, no score increment.
  - `RESET` overrides every event.
- **Reset values:**
  - state IDLE; `game_status` 0; `game_over` 0.
  - `speed` = `SPEED_MIN`; `score` 0x0000; `hiscore` 0x0000.
  - `vs_q` 1; `start_q` 1, so a button held through reset creates no edge.
- **Reset mid-run:** returns to IDLE in one cycle. Score and hiscore are cleared.

## Timing
- All outputs are registered.
- `start_edge` in cycle N → state ARMED in cycle N+1.
- `frame_tick` in cycle N (state ARMED) → `game_status` = 1, `score` = 0 and `speed` = `SPEED_MIN` in cycle N+1.
- `hit` in cycle N (state RUNNING) → `game_status` = 0 and `game_over` = 1 in cycle N+1.
- Score increment on the qualifying `frame_tick` in cycle N → new `score` in cycle N+1. `speed` updates in the same cycle as the score that triggers it.
- `hiscore` updates in the cycle `game_over` first rises, with no extra latency.
- Launch therefore always occurs at a vsync falling edge, during blanking.

## Configuration
- Macro: `GAME_SEQ_HISCORE_EN`.
- **Defined:**
  - On the RUNNING→OVER transition, `hiscore` is loaded with the final score if that score is greater (BCD compare, most significant digit first).
  - `hiscore` is cleared only by `RESET`.
- **Undefined:**
  - The hiscore register and comparator are not built.
  - `hiscore` is tied to 0x0000.

## Structure
- Shared package `game_pkg`:
  - state enum `game_state_t` (IDLE, ARMED, RUNNING, OVER; 2 bits).
  - `SCORE_DIGITS` = 4.
  - `BCD_MAX` = 16'h9999.
  - Speed width = 4.
- One sub-module, `bcd_counter4`:
  - Inputs: clear and increment enable.
  - Outputs: 16-bit BCD value and a `sat` flag.
  - The `sat` flag also gates the level counter.

## Test plan
- **Reset, then launch:** `RESET` high then low; pulse `start`; drop `vs` 20 cycles later → ARMED for 20 cycles; `game_status` = 1 exactly one cycle after the `vs` fall; `speed` = 1; `score` = 0x0000.
- **Scoring and speed step:** `FRAMES_PER_POINT` = 6, `POINTS_PER_LEVEL` = 100; run 600 frames → `score` = 0x0100, `speed` = 2; BCD carry seen at 0x0009→0x0010.
- **Collision:** assert `px_dinosaur` & `px_cactus` for one cycle in RUNNING → next cycle `game_status` = 0, `game_over` = 1; `score` frozen. Hit together with the 6th `frame_tick` → no increment.
- **Saturation:**
  - Force score to 0x9998, `speed` at 8; run 12 frames → `score` = 0x9999, `speed` = 8, no wrap.
  - Stretch: with `POINTS_PER_LEVEL` = 1, run 20 points → `speed` stops at 8.
- **Hiscore** (macro defined): run 1 ends at 0x0042, run 2 ends at 0x0017 → `hiscore` = 0x0042. Start again → OVER→ARMED; `start` held for 100 cycles yields one edge only.
- **Reset mid-run and macro off:** `RESET` pulsed in RUNNING → IDLE next cycle, all outputs at reset values. With the macro undefined, `hiscore` stays 0x0000 in every scenario.
